// File: rtl/rv_decode_pkg.sv
// Shared definitions for the RV64IM decode stage.
//  - Opcode constants for the base integer ISA (plus the W-variants).
//  - Instruction class codes reported on out_type.
//  - funct7 values that separate base, alternate (SUB/SRA) and M-extension ops.
//  - Immediate format selector used between the decoder and imm_gen.
package rv_decode_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  localparam logic [3:0] TYPE_ILLEGAL   = 4'd0;
  localparam logic [3:0] TYPE_R         = 4'd1;
  localparam logic [3:0] TYPE_I_ALU     = 4'd2;
  localparam logic [3:0] TYPE_LOAD      = 4'd3;
  localparam logic [3:0] TYPE_S         = 4'd4;
  localparam logic [3:0] TYPE_B         = 4'd5;
  localparam logic [3:0] TYPE_JAL       = 4'd6;
  localparam logic [3:0] TYPE_JALR      = 4'd7;
  localparam logic [3:0] TYPE_LUI       = 4'd8;
  localparam logic [3:0] TYPE_AUIPC     = 4'd9;
  localparam logic [3:0] TYPE_OP_32     = 4'd10;
  localparam logic [3:0] TYPE_OP_IMM_32 = 4'd11;
  localparam logic [3:0] TYPE_MEXT      = 4'd12;

  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;
  localparam logic [6:0] FUNCT7_MEXT = 7'h01;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_SHAMT,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // Register-register funct7 check: 0x20 only selects SUB (funct3 000)
  // and SRA (funct3 101); every other op must use the base funct7.
  function automatic logic r_funct_ok(input logic [6:0] funct7, input logic [2:0] funct3);
    return (funct7 == FUNCT7_BASE) ||
           ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational immediate builder.
//  instr  in   32    raw instruction
//  fmt    in   enum  immediate format chosen by the decoder
//  imm    out  XLEN  immediate, sign-extended from its top bit (shamt zero-extended)
module imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  // Built at 64 bits and truncated, so the XLEN=32 build needs no
  // zero-width replications.
  logic [63:0] imm64;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    imm64 = '0;
    case (fmt)
      IMM_I:     imm64 = {{52{instr[31]}}, instr[31:20]};
      IMM_SHAMT: imm64 = (XLEN == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
      IMM_S:     imm64 = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:     imm64 = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:     imm64 = {{32{instr[31]}}, instr[31:12], 12'b0};
      IMM_J:     imm64 = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:   imm64 = '0;
    endcase
  end

  assign imm = imm64[XLEN-1:0];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV64IM decode stage between fetch and execute.
// Holds one decoded entry behind a valid/ready handshake; flush drops both
// the held entry and whatever is presented this cycle.
//  clk, rst_n                 clock, synchronous active-low reset
//  flush                      drop held entry and current input
//  in_valid/in_ready          fetch handshake; in_instr, in_pc payload
//  out_valid/out_ready        execute handshake
//  out_pc, out_type, out_imm  registered PC, class code, immediate
//  out_opcode..out_funct7     raw instruction fields of the held entry
//  out_illegal                held entry is an illegal encoding
// Build option: define RV_MEXT_EN to decode MUL/DIV (and W forms on RV64).
module decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PC_W = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [3:0]      out_type,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

`ifdef RV_MEXT_EN
  localparam bit MEXT_EN = 1'b1;
`else
  localparam bit MEXT_EN = 1'b0;
`endif

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [3:0]      dec_type;
  imm_fmt_e        dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic [31:0]     held_instr;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  // Unknown opcodes, instr[1:0] != 2'b11 and the all-zero word all fall
  // through to the default illegal classification.
  always_comb begin
    dec_type = TYPE_ILLEGAL;
    dec_fmt  = IMM_NONE;
    case (opc)
      OPC_OP: begin
        if (r_funct_ok(f7, f3))                   dec_type = TYPE_R;
        else if (MEXT_EN && (f7 == FUNCT7_MEXT))  dec_type = TYPE_MEXT;
      end
      OPC_OP_32: begin
        if (XLEN == 64) begin
          if (r_funct_ok(f7, f3))                  dec_type = TYPE_OP_32;
          else if (MEXT_EN && (f7 == FUNCT7_MEXT)) dec_type = TYPE_MEXT;
        end
      end
      OPC_OP_IMM: begin
        dec_type = TYPE_I_ALU;
        dec_fmt  = ((f3 == 3'b001) || (f3 == 3'b101)) ? IMM_SHAMT : IMM_I;
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          dec_type = TYPE_OP_IMM_32;
          dec_fmt  = IMM_I;
        end
      end
      OPC_LOAD: begin
        if (f3 != 3'b111) begin
          dec_type = TYPE_LOAD;
          dec_fmt  = IMM_I;
        end
      end
      OPC_STORE: begin
        if (f3 <= 3'b011) begin
          dec_type = TYPE_S;
          dec_fmt  = IMM_S;
        end
      end
      OPC_BRANCH: begin
        if ((f3 != 3'b010) && (f3 != 3'b011)) begin
          dec_type = TYPE_B;
          dec_fmt  = IMM_B;
        end
      end
      OPC_JALR: begin
        if (f3 == 3'b000) begin
          dec_type = TYPE_JALR;
          dec_fmt  = IMM_I;
        end
      end
      OPC_JAL:   begin dec_type = TYPE_JAL;   dec_fmt = IMM_J; end
      OPC_LUI:   begin dec_type = TYPE_LUI;   dec_fmt = IMM_U; end
      OPC_AUIPC: begin dec_type = TYPE_AUIPC; dec_fmt = IMM_U; end
      default: ;
    endcase
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  assign in_ready = !out_valid || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      held_instr <= '0;
      out_pc     <= '0;
      out_type   <= TYPE_ILLEGAL;
      out_imm    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid  <= 1'b1;
      held_instr <= in_instr;
      out_pc     <= in_pc;
      out_type   <= dec_type;
      out_imm    <= dec_imm;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_opcode  = held_instr[6:0];
  assign out_rd      = held_instr[11:7];
  assign out_funct3  = held_instr[14:12];
  assign out_rs1     = held_instr[19:15];
  assign out_rs2     = held_instr[24:20];
  assign out_funct7  = held_instr[31:25];
  // Qualified by out_valid so an empty stage never reports illegal.
  assign out_illegal = out_valid && (out_type == TYPE_ILLEGAL);

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed steps followed by random
// traffic, checked against a spec-level decode model and a queue scoreboard.
module tb_decode_stage;

  localparam int XLEN = 64;
  localparam int PC_W = 64;
`ifdef RV_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [3:0]      out_type;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_type    (out_type),
    .out_opcode  (out_opcode),
    .out_rd      (out_rd),
    .out_funct3  (out_funct3),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_funct7  (out_funct7),
    .out_imm     (out_imm),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    int          typ;
    longint      imm;
  } entry_t;

  entry_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input longint v, input int bits);
    longint half;
    half = longint'(1) << (bits - 1);
    return (v >= half) ? v - (half << 1) : v;
  endfunction

  function automatic bit r_ok(input int f7, input int f3);
    return (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
  endfunction

  // Reference decode straight from the ISA rules, using integer arithmetic.
  function automatic void ref_decode(input logic [31:0] i, output int t, output longint imm);
    int op, f3, f7;
    longint iv, sv, bv, jv, uv;
    op = int'(i[6:0]);
    f3 = int'(i[14:12]);
    f7 = int'(i[31:25]);
    iv = sx(longint'(i[31:20]), 12);
    sv = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
    bv = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
            longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
    jv = sx(longint'(i[31]) * (1 << 20) + longint'(i[19:12]) * 4096 +
            longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
    uv = sx(longint'(i[31:12]) * 4096, 32);
    t = 0;
    imm = 0;
    case (op)
      'h33: t = r_ok(f7, f3) ? 1 : ((MEXT && f7 == 1) ? 12 : 0);
      'h3B: t = (XLEN == 32) ? 0 : (r_ok(f7, f3) ? 10 : ((MEXT && f7 == 1) ? 12 : 0));
      'h13: begin t = 2; imm = (f3 == 1 || f3 == 5) ? longint'(i[25:20]) : iv; end
      'h1B: begin t = (XLEN == 32) ? 0 : 11; imm = iv; end
      'h03: begin t = (f3 == 7) ? 0 : 3; imm = iv; end
      'h23: begin t = (f3 > 3) ? 0 : 4; imm = sv; end
      'h63: begin t = (f3 == 2 || f3 == 3) ? 0 : 5; imm = bv; end
      'h6F: begin t = 6; imm = jv; end
      'h67: begin t = (f3 != 0) ? 0 : 7; imm = iv; end
      'h37: begin t = 8; imm = uv; end
      'h17: begin t = 9; imm = uv; end
      default: t = 0;
    endcase
    if (t == 0) imm = 0;
  endfunction

  task automatic check_outputs();
    if (q.size() != 0) begin
      check("out_pc", out_pc, q[0].pc);
      check("out_type", 64'(out_type), 64'(q[0].typ));
      check("out_imm", out_imm, q[0].imm);
      check("out_opcode", 64'(out_opcode), 64'(q[0].instr[6:0]));
      check("out_rd", 64'(out_rd), 64'(q[0].instr[11:7]));
      check("out_funct3", 64'(out_funct3), 64'(q[0].instr[14:12]));
      check("out_rs1", 64'(out_rs1), 64'(q[0].instr[19:15]));
      check("out_rs2", 64'(out_rs2), 64'(q[0].instr[24:20]));
      check("out_funct7", 64'(out_funct7), 64'(q[0].instr[31:25]));
      check("out_illegal", 64'(out_illegal), 64'(q[0].typ == 0));
    end else begin
      check("out_illegal_idle", 64'(out_illegal), 64'd0);
    end
  endtask

  // One cycle: drive at negedge, check, then advance the scoreboard at posedge.
  task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                      input bit rdy, input bit fl);
    bit     exp_ready;
    entry_t e;
    @(negedge clk);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    #1;
    exp_ready = (q.size() == 0) || rdy;
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check_outputs();
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (v && exp_ready) begin
        e.instr = ins;
        e.pc    = pc;
        ref_decode(ins, e.typ, e.imm);
        q.push_back(e);
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  ops [11] = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h23,
                              7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    logic [6:0]  f7s [3]  = '{7'h00, 7'h20, 7'h01};
    int k;
    ins = $urandom;
    k = $urandom_range(0, 13);
    if (k < 11) ins[6:0] = ops[k];
    if ($urandom_range(0, 1) == 0) ins[31:25] = f7s[$urandom_range(0, 2)];
    if (k == 12) ins = 32'h0;
    return ins;
  endfunction

  initial begin
    logic [31:0] ri;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093;
    in_pc     = 64'h1000;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_imm", out_imm, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_type", 64'(out_type), 64'd0);
    check("rst_out_illegal", 64'(out_illegal), 64'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // ADDI x1,x0,-1
    step(1, 32'hFFF00093, 64'h1000, 1, 0);
    #1;
    check("addi_type", 64'(out_type), 64'd2);
    check("addi_rd", 64'(out_rd), 64'd1);
    check("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);

    // BEQ with offset -4
    step(1, 32'hFE000EE3, 64'h1004, 1, 0);
    #1;
    check("beq_type", 64'(out_type), 64'd5);
    check("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);

    // LUI held under back-pressure for three cycles
    step(1, 32'h123450B7, 64'h1008, 1, 0);
    for (int c = 0; c < 3; c++) begin
      step(1, 32'hFFF00093, 64'h100C, 0, 0);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_imm", out_imm, 64'h0000_0000_1234_5000);
    end
    step(1, 32'hFFF00093, 64'h100C, 1, 0);
    #1;
    check("bp_next_valid", 64'(out_valid), 64'd1);
    check("bp_next_type", 64'(out_type), 64'd2);
    check("bp_next_pc", out_pc, 64'h100C);

    // MUL x0,x1,x2
    step(1, 32'h02208033, 64'h1010, 1, 0);
    #1;
    check("mul_type", 64'(out_type), MEXT ? 64'd12 : 64'd0);
    check("mul_illegal", 64'(out_illegal), MEXT ? 64'd0 : 64'd1);

    // Flush with a held entry and a presented instruction
    step(1, 32'hFFF00093, 64'h1014, 0, 1);
    #1;
    check("flush_valid", 64'(out_valid), 64'd0);
    step(0, 32'h0, 64'h0, 1, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      ri = rand_instr();
      step(($urandom_range(0, 9) < 7), ri, {$urandom, $urandom},
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
    end
    step(0, 32'h0, 64'h0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
